// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the shared CPU datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface mc_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
);
  logic [OP_W-1:0]    op;
  logic [OP_W-1:0]    funct;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               i_or_d;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] aluop;
  logic               imm_zext;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               retire;
  logic               illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, aluop, imm_zext, reg_write, reg_dst, mem_to_reg,
           retire, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
           alu_src_b, aluop, imm_zext, reg_write, reg_dst, mem_to_reg,
           retire, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath, one instruction at a time, stalling on the memory handshake.
module mc_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
) (
    input  logic          clock_i,
    input  logic          reset_i,
    mc_ctrl_if.master     bus
);

  typedef logic [ALUOP_W-1:0] aluop_t;
  typedef logic [OP_W-1:0]    op_t;

  localparam aluop_t ALU_ADD = 4'd0;
  localparam aluop_t ALU_SUB = 4'd1;
  localparam aluop_t ALU_AND = 4'd2;
  localparam aluop_t ALU_OR  = 4'd3;
  localparam aluop_t ALU_XOR = 4'd4;
  localparam aluop_t ALU_NOR = 4'd5;
  localparam aluop_t ALU_SLT = 4'd6;
  localparam aluop_t ALU_SLL = 4'd7;
  localparam aluop_t ALU_SRL = 4'd8;
  localparam aluop_t ALU_LUI = 4'd9;

  localparam op_t OP_RTYPE = 6'h00;
  localparam op_t OP_ADDI  = 6'h08;
  localparam op_t OP_ADDIU = 6'h09;
  localparam op_t OP_ANDI  = 6'h0C;
  localparam op_t OP_ORI   = 6'h0D;
  localparam op_t OP_LUI   = 6'h0F;
  localparam op_t OP_LW    = 6'h23;
  localparam op_t OP_SW    = 6'h2B;
  localparam op_t OP_BEQ   = 6'h04;
  localparam op_t OP_J     = 6'h02;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  state_e state_q, state_d;

  // Instruction decode; op/funct come from the IR and stay stable until the next fetch.
  logic   r_legal, i_legal, i_zext;
  aluop_t r_aluop, i_aluop;

  always_comb begin
    r_legal = 1'b0;
    r_aluop = ALU_ADD;
    if (bus.op == OP_RTYPE) begin
      r_legal = 1'b1;
      case (bus.funct)
        6'h20, 6'h21: r_aluop = ALU_ADD;
        6'h22, 6'h23: r_aluop = ALU_SUB;
        6'h24:        r_aluop = ALU_AND;
        6'h25:        r_aluop = ALU_OR;
        6'h26:        r_aluop = ALU_XOR;
        6'h27:        r_aluop = ALU_NOR;
        6'h2A:        r_aluop = ALU_SLT;
        6'h00:        r_aluop = ALU_SLL;
        6'h02:        r_aluop = ALU_SRL;
        default:      r_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    i_legal = 1'b1;
    i_aluop = ALU_ADD;
    i_zext  = 1'b0;
    case (bus.op)
      OP_ADDI, OP_ADDIU: i_aluop = ALU_ADD;
      OP_ANDI: begin i_aluop = ALU_AND; i_zext = 1'b1; end
      OP_ORI:  begin i_aluop = ALU_OR;  i_zext = 1'b1; end
      OP_LUI:  i_aluop = ALU_LUI;
      default: i_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a;
  logic       imm_zext, reg_write, reg_dst, mem_to_reg, retire, illegal;
  logic [1:0] pc_src, alu_src_b;
  aluop_t     aluop;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    aluop      = ALU_ADD;
    imm_zext   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the register file is read.
        alu_src_b = 2'd3;
        if (r_legal)                              state_d = S_EXEC_R;
        else if (i_legal)                         state_d = S_EXEC_I;
        else if (bus.op == OP_LW || bus.op == OP_SW) state_d = S_MEM_ADDR;
        else if (bus.op == OP_BEQ)                state_d = S_BRANCH;
        else if (bus.op == OP_J)                  state_d = S_JUMP;
        else                                      state_d = S_TRAP;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = r_aluop;
        reg_dst   = 1'b1;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        aluop     = i_aluop;
        imm_zext  = i_zext;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (bus.op == OP_RTYPE);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALU_SUB;
        pc_src    = 2'd1;
        pc_write  = bus.zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts whatever is in flight: nothing leaves the controller that cycle.
    if (reset_i) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      aluop      = ALU_ADD;
      imm_zext   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.i_or_d     = i_or_d;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.aluop      = aluop;
  assign bus.imm_zext   = imm_zext;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.retire     = retire;
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: cycle-script table, hand-written corner sequences, then
// random instructions with random memory stalls checked against a transaction model.
module tb_mc_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mc_ctrl_if bus ();

  mc_ctrl u_dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // exp: one char per output, '-' = don't care. Order:
  // mem_req mem_we i_or_d ir_write pc_write pc_src alu_src_a alu_src_b aluop
  // imm_zext reg_write reg_dst mem_to_reg retire illegal
  typedef struct {
    bit         rst;
    logic [5:0] op;
    logic [5:0] funct;
    bit         zero;
    bit         rdy;
    string      exp;
  } vec_t;

  vec_t tbl[$];

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_TRAP = 6;

  task automatic step(input bit r, input logic [5:0] o, input logic [5:0] f,
                      input bit z, input bit rdy);
    @(negedge clock);
    reset         = r;
    bus.op        = o;
    bus.funct     = f;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic string outs_str();
    int a[15];
    string s;
    a[0] = int'(bus.mem_req);   a[1] = int'(bus.mem_we);    a[2] = int'(bus.i_or_d);
    a[3] = int'(bus.ir_write);  a[4] = int'(bus.pc_write);  a[5] = int'(bus.pc_src);
    a[6] = int'(bus.alu_src_a); a[7] = int'(bus.alu_src_b); a[8] = int'(bus.aluop);
    a[9] = int'(bus.imm_zext);  a[10] = int'(bus.reg_write); a[11] = int'(bus.reg_dst);
    a[12] = int'(bus.mem_to_reg); a[13] = int'(bus.retire); a[14] = int'(bus.illegal);
    s = "";
    for (int i = 0; i < 15; i++) s = {s, $sformatf("%0h", a[i])};
    return s;
  endfunction

  task automatic apply_row(input int idx, input vec_t v);
    string act;
    bit    ok;
    step(v.rst, v.op, v.funct, v.zero, v.rdy);
    act = outs_str();
    ok  = 1'b1;
    for (int i = 0; i < 15; i++)
      if (v.exp[i] != "-" && v.exp[i] != act[i]) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL row%0d op=%02h funct=%02h: got %s, expected %s", idx, v.op, v.funct, act, v.exp);
    end else begin
      $display("row%0d op=%02h rst=%0d rdy=%0d outs=%s", idx, v.op, v.rst, v.rdy, act);
    end
  endtask

  // Transaction-level view of an instruction: its class and what the ALU must do.
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] funct,
                                     output int kind, output int aop, output int zx);
    kind = K_TRAP; aop = 0; zx = 0;
    case (op)
      6'h00: begin
        kind = K_R;
        case (funct)
          6'h20, 6'h21: aop = 0;
          6'h22, 6'h23: aop = 1;
          6'h24: aop = 2;
          6'h25: aop = 3;
          6'h26: aop = 4;
          6'h27: aop = 5;
          6'h2A: aop = 6;
          6'h00: aop = 7;
          6'h02: aop = 8;
          default: kind = K_TRAP;
        endcase
      end
      6'h08, 6'h09: begin kind = K_I; aop = 0; end
      6'h0C: begin kind = K_I; aop = 2; zx = 1; end
      6'h0D: begin kind = K_I; aop = 3; zx = 1; end
      6'h0F: begin kind = K_I; aop = 9; end
      6'h23: kind = K_LW;
      6'h2B: kind = K_SW;
      6'h04: kind = K_BEQ;
      6'h02: kind = K_J;
      default: kind = K_TRAP;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    logic [5:0] r_functs[11];
    logic [5:0] i_ops[5];
    logic [2:0] prev_m;
    bit   z, rdy, prev_stall, ill;
    int   cat, kind, eaop, ezx, cycles, stalls, memtx, tx1, tx2, irw, pcw, rw, ret;
    int   cap, ecap, rwinfo, unstable, base, reqs;

    r_functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
    i_ops    = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F};

    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    // ---- cycle script ----
    tbl.push_back('{1'b1, 6'h00, 6'h00, 1'b0, 1'b0, "000000000000000"});
    tbl.push_back('{1'b1, 6'h00, 6'h00, 1'b0, 1'b0, "000000000000000"});
    // add
    tbl.push_back('{1'b0, 6'h00, 6'h20, 1'b0, 1'b1, "100110010-0--00"});
    tbl.push_back('{1'b0, 6'h00, 6'h20, 1'b0, 1'b1, "0--00-030-0--00"});
    tbl.push_back('{1'b0, 6'h00, 6'h20, 1'b0, 1'b1, "0--00-100-0--00"});
    tbl.push_back('{1'b0, 6'h00, 6'h20, 1'b0, 1'b1, "0--00---0-11010"});
    // beq taken, with one fetch stall
    tbl.push_back('{1'b0, 6'h04, 6'h00, 1'b1, 1'b0, "10000-010-0--00"});
    tbl.push_back('{1'b0, 6'h04, 6'h00, 1'b1, 1'b1, "100110010-0--00"});
    tbl.push_back('{1'b0, 6'h04, 6'h00, 1'b1, 1'b1, "0--00-030-0--00"});
    tbl.push_back('{1'b0, 6'h04, 6'h00, 1'b1, 1'b1, "0--011101-0--10"});
    // beq not taken
    tbl.push_back('{1'b0, 6'h04, 6'h00, 1'b0, 1'b1, "100110010-0--00"});
    tbl.push_back('{1'b0, 6'h04, 6'h00, 1'b0, 1'b1, "0--00-030-0--00"});
    tbl.push_back('{1'b0, 6'h04, 6'h00, 1'b0, 1'b1, "0--001101-0--10"});
    // sw with one write stall
    tbl.push_back('{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, "100110010-0--00"});
    tbl.push_back('{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, "0--00-030-0--00"});
    tbl.push_back('{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, "0--00-12000--00"});
    tbl.push_back('{1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, "11100-----0--00"});
    tbl.push_back('{1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, "11100-----0--10"});
    // j
    tbl.push_back('{1'b0, 6'h02, 6'h00, 1'b0, 1'b1, "100110010-0--00"});
    tbl.push_back('{1'b0, 6'h02, 6'h00, 1'b0, 1'b1, "0--00-030-0--00"});
    tbl.push_back('{1'b0, 6'h02, 6'h00, 1'b0, 1'b1, "0--012----0--10"});
    // ori
    tbl.push_back('{1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, "100110010-0--00"});
    tbl.push_back('{1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, "0--00-030-0--00"});
    tbl.push_back('{1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, "0--00-12310--00"});
    tbl.push_back('{1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, "0--00-----10010"});

    foreach (tbl[i]) apply_row(i, tbl[i]);

    // ---- lw with two wait cycles in the read phase: writeback lands on cycle 7 ----
    step(0, 6'h23, 6'h00, 0, 1); chk("lw fetch ir_write", int'(bus.ir_write), 1);
    step(0, 6'h23, 6'h00, 0, 1); chk("lw decode mem_req", int'(bus.mem_req), 0);
    step(0, 6'h23, 6'h00, 0, 1); chk("lw addr alu_src_b", int'(bus.alu_src_b), 2);
    reqs = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 6'h23, 6'h00, 0, k == 2);
      reqs += int'(bus.mem_req);
      chk("lw read i_or_d", int'(bus.i_or_d), 1);
      chk("lw read mem_we", int'(bus.mem_we), 0);
      chk("lw read reg_write", int'(bus.reg_write), 0);
    end
    chk("lw mem_req held cycles", reqs, 3);
    step(0, 6'h23, 6'h00, 0, 0);
    chk("lw wb reg_write", int'(bus.reg_write), 1);
    chk("lw wb mem_to_reg", int'(bus.mem_to_reg), 1);
    chk("lw wb reg_dst", int'(bus.reg_dst), 0);
    chk("lw wb retire", int'(bus.retire), 1);
    $display("lw stall sequence done");

    // ---- illegal opcode traps until reset ----
    step(0, 6'h3F, 6'h00, 0, 1);
    step(0, 6'h3F, 6'h00, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 6'h3F, 6'h00, 0, 1'($urandom_range(0, 1)));
      chk("trap illegal", int'(bus.illegal), 1);
      chk("trap mem_req", int'(bus.mem_req), 0);
      chk("trap retire", int'(bus.retire), 0);
    end
    step(1, 6'h3F, 6'h00, 0, 1); chk("trap reset illegal", int'(bus.illegal), 0);
    step(0, 6'h3F, 6'h00, 0, 0);
    chk("trap released illegal", int'(bus.illegal), 0);
    chk("trap released mem_req", int'(bus.mem_req), 1);
    $display("trap sequence done");

    // ---- reset while add sits in EXEC_R: its writeback must never happen ----
    step(0, 6'h00, 6'h20, 0, 1);
    step(0, 6'h00, 6'h20, 0, 1);
    step(1, 6'h00, 6'h20, 0, 1);
    chk("abort reg_write", int'(bus.reg_write), 0);
    chk("abort alu_src_a", int'(bus.alu_src_a), 0);
    step(0, 6'h00, 6'h20, 0, 0);
    chk("abort then reg_write", int'(bus.reg_write), 0);
    chk("abort then fetch mem_req", int'(bus.mem_req), 1);
    $display("abort sequence done");

    // ---- random instructions with random stalls ----
    for (int n = 0; n < 150; n++) begin
      cat = $urandom_range(0, 9);
      fn  = 6'($urandom_range(0, 63));
      z   = 1'($urandom_range(0, 1));
      case (cat)
        0, 1, 2, 3: begin op = 6'h00; fn = r_functs[$urandom_range(0, 10)]; end
        4, 5:       op = i_ops[$urandom_range(0, 4)];
        6:          op = 6'h23;
        7:          op = 6'h2B;
        8:          op = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h02;
        default:    op = 6'($urandom_range(0, 63));
      endcase
      ref_decode(op, fn, kind, eaop, ezx);

      cycles = 0; stalls = 0; memtx = 0; tx1 = -1; tx2 = -1; irw = 0; pcw = 0;
      rw = 0; ret = 0; cap = -1; rwinfo = -1; unstable = 0; ill = 0;
      prev_stall = 0; prev_m = '0;
      while (ret == 0 && !ill && cycles < 60) begin
        rdy = ($urandom_range(0, 3) != 0);
        step(0, op, fn, z, rdy);
        cycles++;
        if (prev_stall && {bus.mem_req, bus.mem_we, bus.i_or_d} !== prev_m) unstable++;
        prev_stall = bus.mem_req && !rdy;
        prev_m     = {bus.mem_req, bus.mem_we, bus.i_or_d};
        if (bus.mem_req && !rdy) stalls++;
        if (bus.mem_req && rdy) begin
          memtx++;
          if (memtx == 1) tx1 = 2 * int'(bus.i_or_d) + int'(bus.mem_we);
          else            tx2 = 2 * int'(bus.i_or_d) + int'(bus.mem_we);
        end
        irw += int'(bus.ir_write);
        pcw += int'(bus.pc_write);
        rw  += int'(bus.reg_write);
        if (bus.reg_write) rwinfo = 10 * int'(bus.reg_dst) + int'(bus.mem_to_reg);
        if (bus.alu_src_a && cap < 0)
          cap = 100 * int'(bus.alu_src_b) + 10 * int'(bus.aluop) + int'(bus.imm_zext);
        if (bus.illegal) ill = 1;
        ret += int'(bus.retire);
      end
      $display("instr %0d op=%02h funct=%02h kind=%0d zero=%0d cycles=%0d stalls=%0d",
               n, op, fn, kind, z, cycles, stalls);

      chk("rnd ir_write count", irw, 1);
      chk("rnd fetch transfer", tx1, 0);
      chk("rnd mem stable while waiting", unstable, 0);
      if (kind == K_TRAP) begin
        chk("rnd trap illegal", int'(ill), 1);
        chk("rnd trap latency", cycles, 3 + stalls);
        chk("rnd trap retire", ret, 0);
        for (int k = 0; k < 3; k++) begin
          step(0, op, fn, z, 1'($urandom_range(0, 1)));
          chk("rnd trap hold", int'(bus.illegal) * 10 + int'(bus.mem_req), 10);
        end
        step(1, op, fn, z, 0);
        chk("rnd trap reset illegal", int'(bus.illegal), 0);
      end else begin
        case (kind)
          K_R:     base = 4;
          K_I:     base = 4;
          K_LW:    base = 5;
          K_SW:    base = 4;
          default: base = 3;
        endcase
        case (kind)
          K_R:     ecap = 10 * eaop;
          K_I:     ecap = 200 + 10 * eaop + ezx;
          K_LW:    ecap = 200;
          K_SW:    ecap = 200;
          K_BEQ:   ecap = 10;
          default: ecap = -1;
        endcase
        chk("rnd retire", ret, 1);
        chk("rnd illegal", int'(ill), 0);
        chk("rnd latency", cycles, base + stalls);
        chk("rnd pc_write count", pcw, 1 + ((kind == K_J) ? 1 : 0) + ((kind == K_BEQ) ? int'(z) : 0));
        chk("rnd reg_write count", rw, (kind == K_R || kind == K_I || kind == K_LW) ? 1 : 0);
        chk("rnd writeback select", rwinfo,
            (kind == K_R) ? 10 : (kind == K_I) ? 0 : (kind == K_LW) ? 1 : -1);
        chk("rnd alu setup", cap, ecap);
        chk("rnd mem transfers", memtx, (kind == K_LW || kind == K_SW) ? 2 : 1);
        chk("rnd data transfer", tx2, (kind == K_LW) ? 2 : (kind == K_SW) ? 3 : -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
